wave_sequencer: RTL and testbench
=================================

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter FW_W, default 16: phase accumulator and frequency word width.
REQ-002 SHALL have parameter ROM_LAT, default 2: clocks from rom_addr update to valid rom_q.
REQ-003 SHALL have parameter FREQ_STEP, default 16: frequency word increment per key press.
REQ-004 SHALL have parameter FREQ_INIT, default 64: frequency word reset value.
REQ-005 SHALL have port clk, in, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, in, 1: asynchronous active-low reset.
REQ-007 SHALL have port sample_tick, in, 1: one-clock pulse at the sample rate.
REQ-008 SHALL have ports key_up, key_down, key_left, key_right, key_enter, in, 1 each: one-clock debounced press pulses.
REQ-009 SHALL have port rom_addr, out, 11: sine ROM address.
REQ-010 SHALL have port rom_q, in, 8: sine ROM data, unsigned, mid-scale 8'h80.
REQ-011 SHALL have port dac_value, out, 8: sample to DAC driver.
REQ-012 SHALL have port dac_strobe, out, 1: one-clock pulse when dac_value updates.
REQ-013 SHALL have ports wave_sel (out, 2), freq_word (out, FW_W) and amp (out, 5): current settings for the display.
REQ-014 SHALL have ports busy (out, 1), high outside IDLE, and overrun (out, 1), a one-clock pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, SHAPE, OUT.
REQ-016 IDLE + sample_tick SHALL do all of: phase += freq_word mod 2^FW_W; latch shadow copies of wave_sel and amp; go to FETCH.
REQ-017 FETCH SHALL register rom_addr = phase[FW_W-1:FW_W-11], then go to WAIT.
REQ-018 WAIT SHALL hold for exactly ROM_LAT clocks, then go to SHAPE.
REQ-019 SHAPE SHALL form raw by shadow wave_sel: 0 sine = rom_q; 1 square = phase MSB ? 255 : 0; 2 triangle = MSB ? ~phase[FW_W-2:FW_W-9] : phase[FW_W-2:FW_W-9]; 3 sawtooth = phase[FW_W-1:FW_W-8].
REQ-020 SHAPE SHALL register scaled = (raw * shadow amp) >> 4, computed with a 13-bit product; amp = 16 passes raw unchanged; amp = 0 yields 0.
REQ-021 OUT SHALL load dac_value with scaled, assert dac_strobe for exactly that clock, and return to IDLE.
REQ-022 Latency SHALL be: tick sampled at edge T gives dac_strobe high in the cycle after edge T+3+ROM_LAT.
REQ-023 sample_tick while busy SHALL be dropped: overrun pulses the same clock, and phase and the in-flight sample are unaffected.
REQ-024 key_up SHALL add FREQ_STEP to freq_word, saturating at 2^FW_W-1; key_down SHALL subtract it, saturating at 1.
REQ-025 key_right SHALL increment amp, saturating at 16; key_left SHALL decrement it, saturating at 0.
REQ-026 key_enter SHALL advance wave_sel 0->1->2->3->0.
REQ-027 key_up with key_down, or key_left with key_right, in the same clock SHALL leave that field unchanged; fields are otherwise independent.
REQ-028 Key updates SHALL take effect on the next clock in any state; an in-flight sample SHALL use its shadow wave_sel and amp, and the freq_word latched at its tick.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE; phase 0; rom_addr 0; freq_word FREQ_INIT; amp 16; wave_sel 0; dac_value 8'h80; dac_strobe, busy and overrun 0.
REQ-030 Reset asserted mid-sequence SHALL abort the sample with no dac_strobe.
REQ-031 After release, the first sample_tick SHALL start a normal sequence.

Verification
REQ-032 Reset, then one tick with ROM model rom_q = addr[7:0] (ROM_LAT 2) -> rom_addr = 2 (phase 64), dac_value 8'h02, strobe 5 clocks after tick.
REQ-033 Enter x3 (wave 3), amp 16, 4 ticks -> phase 256 on the 4th tick, dac_value 8'h01; then amp 8 and wave 1 with phase MSB set -> 8'h7F.
REQ-034 Key_down x10 from reset -> freq_word 1; key_up with key_down in the same clock -> unchanged.
REQ-035 Second tick 2 clocks after the first -> overrun pulse, a single strobe, phase advanced once.
REQ-036 freq_word 16'hFFF0, tick from phase 16'h0020 -> phase wraps to 16'h0010, rom_addr 0.
REQ-037 rst_n low in WAIT -> no strobe; all outputs at REQ-029 values asynchronously.

Source files
------------

// File: rtl/wave_sequencer.sv
// wave_sequencer: per-sample sequencer for a DDS tone generator.
// Each accepted sample_tick advances the phase accumulator and reads the
// sine ROM. The sample is then shaped into one of four waveforms, scaled by
// the amplitude setting and handed to the DAC with a one-clock strobe. Key
// pulses adjust the frequency, amplitude and waveform settings at any time.
module wave_sequencer #(
  parameter int FW_W      = 16,
  parameter int ROM_LAT   = 2,
  parameter int FREQ_STEP = 16,
  parameter int FREQ_INIT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_tick,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_enter,
  output logic [10:0]     rom_addr,
  input  logic [7:0]      rom_q,
  output logic [7:0]      dac_value,
  output logic            dac_strobe,
  output logic [1:0]      wave_sel,
  output logic [FW_W-1:0] freq_word,
  output logic [4:0]      amp,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHAPE,
    OUT
  } state_t;

  localparam int               CNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);
  localparam logic [FW_W:0]    STEP_EXT = (FW_W + 1)'(FREQ_STEP);
  localparam logic [FW_W-1:0]  STEP_W   = FW_W'(FREQ_STEP);
  localparam logic [FW_W-1:0]  INIT_W   = FW_W'(FREQ_INIT);
  localparam logic [4:0]       AMP_MAX  = 5'd16;

  state_t           state_q, state_d;
  logic [FW_W-1:0]  phase_q, phase_d;
  logic [10:0]      rom_addr_q, rom_addr_d;
  logic [FW_W-1:0]  freq_q, freq_d;
  logic [4:0]       amp_q, amp_d;
  logic [1:0]       wave_q, wave_d;
  logic [4:0]       shadow_amp_q, shadow_amp_d;
  logic [1:0]       shadow_wave_q, shadow_wave_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       scaled_q, scaled_d;
  logic [7:0]       dac_q, dac_d;
  logic             strobe_q, strobe_d;

  logic [FW_W:0]    freq_up_sum;
  logic [7:0]       raw;
  logic [12:0]      product;
  logic             unused_bits;

  // State and datapath registers, all cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      rom_addr_q    <= '0;
      freq_q        <= INIT_W;
      amp_q         <= AMP_MAX;
      wave_q        <= 2'd0;
      shadow_amp_q  <= AMP_MAX;
      shadow_wave_q <= 2'd0;
      wait_cnt_q    <= '0;
      scaled_q      <= 8'h00;
      dac_q         <= 8'h80;
      strobe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      rom_addr_q    <= rom_addr_d;
      freq_q        <= freq_d;
      amp_q         <= amp_d;
      wave_q        <= wave_d;
      shadow_amp_q  <= shadow_amp_d;
      shadow_wave_q <= shadow_wave_d;
      wait_cnt_q    <= wait_cnt_d;
      scaled_q      <= scaled_d;
      dac_q         <= dac_d;
      strobe_q      <= strobe_d;
    end
  end

  // Waveform shaping from the shadow selection, then 13-bit amplitude scaling.
  always_comb begin
    raw = 8'h00;
    case (shadow_wave_q)
      2'd0: raw = rom_q;
      2'd1: raw = phase_q[FW_W-1] ? 8'hFF : 8'h00;
      2'd2: raw = phase_q[FW_W-1] ? ~phase_q[FW_W-2 -: 8] : phase_q[FW_W-2 -: 8];
      2'd3: raw = phase_q[FW_W-1 -: 8];
      default: raw = 8'h00;
    endcase
    product = 13'(raw) * 13'(shadow_amp_q);
  end

  // Only bits [11:4] of the product matter: amp <= 16 keeps the result in 8 bits.
  assign unused_bits = ^{product[12], product[3:0]};

  // Sequencer FSM: ticks are only accepted in IDLE, the sample then walks
  // FETCH -> WAIT (ROM latency) -> SHAPE -> OUT and strobes the DAC.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    rom_addr_d    = rom_addr_q;
    shadow_amp_d  = shadow_amp_q;
    shadow_wave_d = shadow_wave_q;
    wait_cnt_d    = wait_cnt_q;
    scaled_d      = scaled_q;
    dac_d         = dac_q;
    strobe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          phase_d       = phase_q + freq_q;
          shadow_amp_d  = amp_q;
          shadow_wave_d = wave_q;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        rom_addr_d = phase_q[FW_W-1 -: 11];
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == CNT_LAST) begin
          state_d = SHAPE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      SHAPE: begin
        scaled_d = product[11:4];
        state_d  = OUT;
      end
      OUT: begin
        dac_d    = scaled_q;
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key handling for the user settings; opposing keys in one clock cancel.
  always_comb begin
    freq_d      = freq_q;
    amp_d       = amp_q;
    wave_d      = wave_q;
    freq_up_sum = {1'b0, freq_q} + STEP_EXT;
    if (key_up && !key_down) begin
      freq_d = freq_up_sum[FW_W] ? '1 : freq_up_sum[FW_W-1:0];
    end else if (key_down && !key_up) begin
      freq_d = ({1'b0, freq_q} > STEP_EXT) ? (freq_q - STEP_W) : FW_W'(1);
    end
    if (key_right && !key_left) begin
      amp_d = (amp_q >= AMP_MAX) ? AMP_MAX : (amp_q + 5'd1);
    end else if (key_left && !key_right) begin
      amp_d = (amp_q == 5'd0) ? 5'd0 : (amp_q - 5'd1);
    end
    if (key_enter) begin
      wave_d = wave_q + 2'd1;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign dac_value  = dac_q;
  assign dac_strobe = strobe_q;
  assign wave_sel   = wave_q;
  assign freq_word  = freq_q;
  assign amp        = amp_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = sample_tick && (state_q != IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed bench for wave_sequencer with a sample-level
// reference model updated once per clock and a ROM whose word is addr[7:0].
module tb_wave_sequencer;

  localparam int FW_W      = 16;
  localparam int ROM_LAT   = 2;
  localparam int FREQ_STEP = 16;
  localparam int FREQ_INIT = 64;
  localparam int PHASE_MOD = 1 << FW_W;
  localparam int HALF      = 1 << (FW_W - 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_tick = 1'b0;
  logic            key_up = 1'b0;
  logic            key_down = 1'b0;
  logic            key_left = 1'b0;
  logic            key_right = 1'b0;
  logic            key_enter = 1'b0;
  logic [10:0]     rom_addr;
  logic [7:0]      rom_q;
  logic [7:0]      dac_value;
  logic            dac_strobe;
  logic [1:0]      wave_sel;
  logic [FW_W-1:0] freq_word;
  logic [4:0]      amp;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int s0 = 0;

  // Reference model state: settings, phase, visible outputs, in-flight sample.
  int m_phase, m_freq, m_amp, m_wave, m_rom_addr, m_dac, m_strobe;
  int m_age, m_fl_addr, m_fl_val;
  bit m_inflight;

  logic [7:0] rom_pipe [ROM_LAT];

  wave_sequencer #(
    .FW_W(FW_W), .ROM_LAT(ROM_LAT), .FREQ_STEP(FREQ_STEP), .FREQ_INIT(FREQ_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_enter(key_enter),
    .rom_addr(rom_addr), .rom_q(rom_q), .dac_value(dac_value),
    .dac_strobe(dac_strobe), .wave_sel(wave_sel), .freq_word(freq_word),
    .amp(amp), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM with ROM_LAT clocks of latency whose contents are addr[7:0].
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr[7:0];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s @%0t: actual=%0d required=%0d", name, $time, actual, expected);
    end
  endtask

  // Expected DAC code for one sample, straight from the waveform definitions.
  function automatic int waveSample(input int w, input int a, input int ph);
    int raw;
    int tri_v;
    raw = 0;
    case (w)
      0: raw = (ph / 32) % 256;
      1: raw = (ph >= HALF) ? 255 : 0;
      2: begin
        tri_v = (ph / 128) % 256;
        raw = (ph >= HALF) ? 255 - tri_v : tri_v;
      end
      default: raw = ph / 256;
    endcase
    return (raw * a) / 16;
  endfunction

  task automatic modelReset();
    m_phase = 0; m_freq = FREQ_INIT; m_amp = 16; m_wave = 0;
    m_rom_addr = 0; m_dac = 128; m_strobe = 0;
    m_inflight = 0; m_age = 0; m_fl_addr = 0; m_fl_val = 0;
  endtask

  // Per-cycle compare of every output, then advance the model over the next edge.
  task automatic checkModel();
    bit accept;
    if (dac_strobe) strobes++;
    if (!rst_n) begin
      modelReset();
    end
    checkOutput("rom_addr", int'(rom_addr), m_rom_addr);
    checkOutput("dac_value", int'(dac_value), m_dac);
    checkOutput("dac_strobe", int'(dac_strobe), m_strobe);
    checkOutput("wave_sel", int'(wave_sel), m_wave);
    checkOutput("freq_word", int'(freq_word), m_freq);
    checkOutput("amp", int'(amp), m_amp);
    checkOutput("busy", int'(busy), int'(m_inflight));
    checkOutput("overrun", int'(overrun), int'(rst_n && sample_tick && m_inflight));
    if (rst_n) begin
      accept = sample_tick && !m_inflight;
      m_strobe = 0;
      if (m_inflight) begin
        m_age++;
        if (m_age == 1) m_rom_addr = m_fl_addr;
        if (m_age == 3 + ROM_LAT) begin
          m_dac = m_fl_val;
          m_strobe = 1;
          m_inflight = 0;
        end
      end
      if (accept) begin
        m_phase = (m_phase + m_freq) % PHASE_MOD;
        m_fl_addr = m_phase / 32;
        m_fl_val = waveSample(m_wave, m_amp, m_phase);
        m_inflight = 1;
        m_age = 0;
      end
      if (key_up && !key_down) m_freq = (m_freq + FREQ_STEP > PHASE_MOD - 1) ? PHASE_MOD - 1 : m_freq + FREQ_STEP;
      else if (key_down && !key_up) m_freq = (m_freq - FREQ_STEP < 1) ? 1 : m_freq - FREQ_STEP;
      if (key_right && !key_left) m_amp = (m_amp + 1 > 16) ? 16 : m_amp + 1;
      else if (key_left && !key_right) m_amp = (m_amp - 1 < 0) ? 0 : m_amp - 1;
      if (key_enter) m_wave = (m_wave + 1) % 4;
    end
  endtask

  task automatic stepClk();
    @(negedge clk);
    checkModel();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit up, input bit down, input bit left,
                               input bit right, input bit enter, input bit tick);
    key_up = up; key_down = down; key_left = left;
    key_right = right; key_enter = enter; sample_tick = tick;
    stepClk();
    key_up = 0; key_down = 0; key_left = 0;
    key_right = 0; key_enter = 0; sample_tick = 0;
  endtask

  task automatic resetPulse();
    rst_n = 0;
    stepClk();
    rst_n = 1;
    stepClk();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dac"}, int'(dac_value), 128);
    checkOutput({tag, "_freq"}, int'(freq_word), FREQ_INIT);
    checkOutput({tag, "_amp"}, int'(amp), 16);
    checkOutput({tag, "_wave"}, int'(wave_sel), 0);
    checkOutput({tag, "_rom_addr"}, int'(rom_addr), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_strobe"}, int'(dac_strobe), 0);
    checkOutput({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    modelReset();
    repeat (2) stepClk();
    checkResetValues("reset");
    rst_n = 1;
    repeat (2) stepClk();

    // First sample: phase 64 -> ROM address 2, sine word 2, strobe 5 clocks on.
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (4) stepClk();
    checkOutput("first_strobe_early", int'(dac_strobe), 0);
    stepClk();
    checkOutput("first_strobe", int'(dac_strobe), 1);
    checkOutput("first_dac", int'(dac_value), 8'h02);
    checkOutput("first_rom_addr", int'(rom_addr), 2);
    repeat (3) stepClk();

    // Sawtooth over four ticks, then half-amplitude square with MSB set.
    resetPulse();
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("wave_saw", int'(wave_sel), 3);
    repeat (4) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      repeat (7) stepClk();
    end
    checkOutput("saw_dac", int'(dac_value), 8'h01);
    repeat (8) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("amp_half", int'(amp), 8);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("wave_square", int'(wave_sel), 1);
    repeat (2044) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_half", int'(freq_word), 32768);
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (7) stepClk();
    checkOutput("square_dac", int'(dac_value), 8'h7F);

    // Zero amplitude on a sawtooth sample that would otherwise be 0x41.
    repeat (8) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("amp_zero", int'(amp), 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (1024) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_c000", int'(freq_word), 16'hC000);
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (7) stepClk();
    checkOutput("amp_zero_dac", int'(dac_value), 0);

    // Frequency and amplitude saturation, opposing keys cancel.
    resetPulse();
    repeat (10) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("freq_floor", int'(freq_word), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("freq_cancel", int'(freq_word), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_up17", int'(freq_word), 17);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("amp_cancel", int'(amp), 16);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("amp_ceiling", int'(amp), 16);
    repeat (17) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("amp_floor", int'(amp), 0);

    // Overrun: second tick two clocks after the first is dropped.
    resetPulse();
    s0 = strobes;
    applyStimulus(0, 0, 0, 0, 0, 1);
    stepClk();
    sample_tick = 1;
    #1;
    checkOutput("overrun_pulse", int'(overrun), 1);
    stepClk();
    sample_tick = 0;
    repeat (8) stepClk();
    checkOutput("overrun_strobes", strobes - s0, 1);
    checkOutput("overrun_dac", int'(dac_value), 8'h02);
    applyStimulus(0, 0, 0, 0, 0, 1);
    stepClk();
    checkOutput("overrun_phase_once", int'(rom_addr), 4);
    repeat (6) stepClk();

    // Phase wrap: freq 0xFFF0 from phase 0x0020 lands on 0x0010.
    resetPulse();
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    repeat (2) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      repeat (7) stepClk();
    end
    checkOutput("wrap_pre_addr", int'(rom_addr), 1);
    repeat (4094) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_fff0", int'(freq_word), 16'hFFF0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    stepClk();
    checkOutput("wrap_addr", int'(rom_addr), 0);
    repeat (6) stepClk();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_ceiling", int'(freq_word), 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("freq_ceiling_hold", int'(freq_word), 16'hFFFF);

    // Reset while waiting on the ROM: no strobe, outputs back to reset values.
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    stepClk();
    checkOutput("mid_busy", int'(busy), 1);
    s0 = strobes;
    rst_n = 0;
    #1;
    checkResetValues("async_reset");
    repeat (2) stepClk();
    rst_n = 1;
    repeat (8) stepClk();
    checkOutput("abort_no_strobe", strobes - s0, 0);

    // First tick after release runs a normal sequence.
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (5) stepClk();
    checkOutput("post_reset_strobe", int'(dac_strobe), 1);
    checkOutput("post_reset_dac", int'(dac_value), 8'h02);
    repeat (3) stepClk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
